// File: rtl/fb_access_scheduler.sv
// Framebuffer port arbiter: scan-out reads own the RAM during active video;
// queued pixel writes and a full-screen clear use the blanking cycles.
module fb_access_scheduler #(
  parameter int ADDR_W     = 19,
  parameter int FB_WORDS   = 307200,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              disp_active_next,
  input  logic [ADDR_W-1:0] disp_addr_next,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  input  logic              clr_req,
  input  logic [7:0]        clr_color,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [1:0]        state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_DISP  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_IDLE  = 2'd3
  } st_t;

  logic [ADDR_W+7:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  level;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        clr_color_reg;
  logic              clr_busy_q;

  st_t               st_q, st_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        wdata_d;
  logic              we_d;
  logic              fifo_full, fifo_empty, push, pop, clr_adv, clr_last;

  // Priority: scan-out, then queued writes, then clear, else idle.
  always_comb begin
    fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    fifo_empty = (level == '0);
    wr_ready   = !fifo_full && !clr_busy_q;
    push       = wr_req && wr_ready;
    clr_last   = (clr_cnt == ADDR_W'(FB_WORDS - 1));
    st_d       = ST_IDLE;
    addr_d     = disp_addr_next;
    wdata_d    = mem_wdata;
    we_d       = 1'b0;
    pop        = 1'b0;
    clr_adv    = 1'b0;
    if (disp_active_next) begin
      st_d = ST_DISP;
    end else if (!fifo_empty) begin
      st_d              = ST_WRITE;
      pop               = 1'b1;
      {addr_d, wdata_d} = fifo_mem[rd_ptr];
      we_d              = 1'b1;
    end else if (clr_busy_q) begin
      st_d    = ST_CLEAR;
      clr_adv = 1'b1;
      addr_d  = clr_cnt;
      wdata_d = clr_color_reg;
      we_d    = 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      st_q      <= ST_DISP;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      st_q      <= st_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we    <= we_d;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (push) fifo_mem[wr_ptr] <= {wr_addr, wr_data};
  end

  // Acceptance and advance are exclusive: the clear only advances while busy.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clr_busy_q    <= 1'b0;
      clr_cnt       <= '0;
      clr_color_reg <= '0;
    end else if (clr_req && !clr_busy_q) begin
      clr_busy_q    <= 1'b1;
      clr_color_reg <= clr_color;
    end else if (clr_adv) begin
      if (clr_last) begin
        clr_busy_q <= 1'b0;
        clr_cnt    <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  assign clr_busy   = clr_busy_q;
  assign fifo_level = level;
  assign state      = st_q;

endmodule

// File: tb/tb_fb_access_scheduler.sv
// Directed self-checking bench for fb_access_scheduler; the framebuffer size
// is reduced so a full clear fits in a short run.
module tb_fb_access_scheduler;

  localparam int ADDR_W = 19;
  localparam int FBW    = 3200;
  localparam int LVL_W  = 5;

  logic              iVGA_CLK = 1'b0;
  logic              iRST_n;
  logic              disp_active_next;
  logic [ADDR_W-1:0] disp_addr_next;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              clr_req;
  logic [7:0]        clr_color;
  logic              clr_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we;
  logic [LVL_W-1:0]  fifo_level;
  logic [1:0]        state;

  int tests = 0;
  int fails = 0;

  fb_access_scheduler #(
    .ADDR_W    (ADDR_W),
    .FB_WORDS  (FBW),
    .FIFO_DEPTH(16),
    .LVL_W     (LVL_W)
  ) dut (
    .iVGA_CLK        (iVGA_CLK),
    .iRST_n          (iRST_n),
    .disp_active_next(disp_active_next),
    .disp_addr_next  (disp_addr_next),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ready        (wr_ready),
    .clr_req         (clr_req),
    .clr_color       (clr_color),
    .clr_busy        (clr_busy),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .fifo_level      (fifo_level),
    .state           (state)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic step();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic test_reset();
    iRST_n = 1'b0; disp_active_next = 1'b1; disp_addr_next = 19'd100;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; clr_color = '0;
    step();
    tests++; if (mem_addr !== 19'd0 || mem_we !== 1'b0 || state !== 2'd0) begin
      fails++; $display("FAIL reset_regs: addr=%0d we=%b state=%0d, need 0/0/0", mem_addr, mem_we, state); end
    tests++; if (clr_busy !== 1'b0 || fifo_level !== 5'd0) begin
      fails++; $display("FAIL reset_busy_level: busy=%b level=%0d, need 0/0", clr_busy, fifo_level); end
    iRST_n = 1'b1;
    step();
    tests++; if (mem_addr !== 19'd100 || mem_we !== 1'b0 || state !== 2'd0) begin
      fails++; $display("FAIL first_disp: addr=%0d we=%b state=%0d, need 100/0/0", mem_addr, mem_we, state); end
    tests++; if (wr_ready !== 1'b1 || fifo_level !== 5'd0) begin
      fails++; $display("FAIL first_ready: ready=%b level=%0d, need 1/0", wr_ready, fifo_level); end
  endtask

  task automatic test_three_writes();
    logic [7:0] d [3];
    int we_seen = 0;
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    disp_active_next = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_req = 1'b1; wr_addr = 19'(5 + i); wr_data = d[i];
      step();
      if (mem_we) we_seen++;
    end
    wr_req = 1'b0;
    tests++; if (fifo_level !== 5'd3 || we_seen != 0) begin
      fails++; $display("FAIL three_queued: level=%0d we_count=%0d, need 3/0", fifo_level, we_seen); end
    disp_active_next = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (mem_we !== 1'b1 || mem_addr !== 19'(5 + i) || mem_wdata !== d[i] || state !== 2'd1) begin
        fails++; $display("FAIL drain3[%0d]: we=%b addr=%0d data=%h state=%0d, need 1/%0d/%h/1",
                          i, mem_we, mem_addr, mem_wdata, state, 5 + i, d[i]); end
    end
    step();
    tests++; if (state !== 2'd3 || mem_we !== 1'b0 || fifo_level !== 5'd0) begin
      fails++; $display("FAIL after_drain3: state=%0d we=%b level=%0d, need 3/0/0", state, mem_we, fifo_level); end
  endtask

  task automatic test_push_pop();
    disp_active_next = 1'b0;
    wr_req = 1'b1; wr_addr = 19'd40; wr_data = 8'hA0;
    step();
    tests++; if (fifo_level !== 5'd1 || mem_we !== 1'b0) begin
      fails++; $display("FAIL pp_push: level=%0d we=%b, need 1/0", fifo_level, mem_we); end
    wr_addr = 19'd41; wr_data = 8'hA1;
    step();
    tests++; if (fifo_level !== 5'd1 || mem_we !== 1'b1 || mem_addr !== 19'd40 || mem_wdata !== 8'hA0) begin
      fails++; $display("FAIL pp_both: level=%0d we=%b addr=%0d data=%h, need 1/1/40/a0", fifo_level, mem_we, mem_addr, mem_wdata); end
    wr_req = 1'b0;
    step();
    tests++; if (fifo_level !== 5'd0 || mem_we !== 1'b1 || mem_addr !== 19'd41 || mem_wdata !== 8'hA1) begin
      fails++; $display("FAIL pp_pop: level=%0d we=%b addr=%0d data=%h, need 0/1/41/a1", fifo_level, mem_we, mem_addr, mem_wdata); end
    step();
  endtask

  task automatic test_full_and_preempt();
    disp_active_next = 1'b1; disp_addr_next = 19'd7;
    for (int i = 0; i < 16; i++) begin
      wr_req = 1'b1; wr_addr = 19'(256 + i); wr_data = 8'(8'h40 + i);
      step();
    end
    tests++; if (fifo_level !== 5'd16 || wr_ready !== 1'b0) begin
      fails++; $display("FAIL full: level=%0d ready=%b, need 16/0", fifo_level, wr_ready); end
    wr_addr = 19'd999; wr_data = 8'hEE;
    step();
    tests++; if (fifo_level !== 5'd16) begin
      fails++; $display("FAIL overflow_rejected: level=%0d, need 16", fifo_level); end
    wr_req = 1'b0; disp_active_next = 1'b0;
    step();
    tests++; if (wr_ready !== 1'b1 || fifo_level !== 5'd15 || mem_we !== 1'b1 || mem_addr !== 19'd256) begin
      fails++; $display("FAIL first_pop: ready=%b level=%0d we=%b addr=%0d, need 1/15/1/256", wr_ready, fifo_level, mem_we, mem_addr); end
    for (int i = 1; i < 14; i++) begin
      step();
      tests++; if (mem_we !== 1'b1 || mem_addr !== 19'(256 + i) || mem_wdata !== 8'(8'h40 + i)) begin
        fails++; $display("FAIL drain16[%0d]: we=%b addr=%0d data=%h, need 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, 256 + i, 8'h40 + i); end
    end
    disp_active_next = 1'b1; disp_addr_next = 19'd200;
    step();
    tests++; if (mem_we !== 1'b0 || mem_addr !== 19'd200 || state !== 2'd0 || fifo_level !== 5'd2) begin
      fails++; $display("FAIL preempt: we=%b addr=%0d state=%0d level=%0d, need 0/200/0/2", mem_we, mem_addr, state, fifo_level); end
    disp_active_next = 1'b0;
    for (int i = 14; i < 16; i++) begin
      step();
      tests++; if (mem_we !== 1'b1 || mem_addr !== 19'(256 + i) || mem_wdata !== 8'(8'h40 + i)) begin
        fails++; $display("FAIL resume[%0d]: we=%b addr=%0d data=%h, need 1/%0d/%h", i, mem_we, mem_addr, mem_wdata, 256 + i, 8'h40 + i); end
    end
    step();
    tests++; if (mem_we !== 1'b0 || fifo_level !== 5'd0 || state !== 2'd3) begin
      fails++; $display("FAIL resume_done: we=%b level=%0d state=%0d, need 0/0/3", mem_we, fifo_level, state); end
  endtask

  task automatic test_clear();
    int exp_addr = 0;
    int bad_data = 0, bad_act = 0, bad_ready = 0, bad_busy = 0;
    logic act;
    clr_color = 8'h3C; clr_req = 1'b1; disp_active_next = 1'b1;
    step();
    clr_req = 1'b0;
    tests++; if (clr_busy !== 1'b1 || wr_ready !== 1'b0) begin
      fails++; $display("FAIL clr_accept: busy=%b ready=%b, need 1/0", clr_busy, wr_ready); end
    for (int r = 0; r < 21; r++) begin
      for (int i = 0; i < 800; i++) begin
        disp_active_next = (i >= 160);
        if (r == 5 && i == 0) begin clr_req = 1'b1; clr_color = 8'h55; end
        else clr_req = 1'b0;
        act = disp_active_next;
        step();
        if (act && mem_we) bad_act++;
        if (clr_busy && wr_ready) bad_ready++;
        if (mem_we) begin
          if (mem_addr !== 19'(exp_addr) || mem_wdata !== 8'h3C) bad_data++;
          exp_addr++;
          if (clr_busy !== (exp_addr != FBW)) bad_busy++;
        end
      end
    end
    tests++; if (exp_addr != FBW) begin
      fails++; $display("FAIL clr_count: writes=%0d, need %0d", exp_addr, FBW); end
    tests++; if (bad_data != 0) begin
      fails++; $display("FAIL clr_addr_data: bad writes=%0d, need 0", bad_data); end
    tests++; if (bad_act != 0) begin
      fails++; $display("FAIL clr_we_in_active: count=%0d, need 0", bad_act); end
    tests++; if (bad_ready != 0 || bad_busy != 0) begin
      fails++; $display("FAIL clr_ready_busy: ready_bad=%0d busy_bad=%0d, need 0/0", bad_ready, bad_busy); end
    tests++; if (clr_busy !== 1'b0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL clr_end: busy=%b ready=%b, need 0/1", clr_busy, wr_ready); end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    int stray = 0;
    disp_active_next = 1'b1;
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 19'(512 + i); wr_data = 8'(i);
      step();
    end
    wr_req = 1'b0; clr_req = 1'b1; clr_color = 8'h3C;
    step();
    clr_req = 1'b0;
    tests++; if (fifo_level !== 5'd4 || clr_busy !== 1'b1) begin
      fails++; $display("FAIL rst_setup: level=%0d busy=%b, need 4/1", fifo_level, clr_busy); end
    disp_active_next = 1'b0;
    for (int g = 0; g < 2000 && n < 1000; g++) begin
      step();
      if (mem_we && state == 2'd2) n++;
    end
    tests++; if (n != 1000) begin
      fails++; $display("FAIL rst_reach_1000: clear writes=%0d, need 1000 (timeout)", n); end
    iRST_n = 1'b0;
    #1;
    tests++; if (mem_we !== 1'b0 || clr_busy !== 1'b0 || fifo_level !== 5'd0 || state !== 2'd0 || mem_addr !== 19'd0) begin
      fails++; $display("FAIL async_reset: we=%b busy=%b level=%0d state=%0d addr=%0d, need 0/0/0/0/0",
                        mem_we, clr_busy, fifo_level, state, mem_addr); end
    step();
    iRST_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (mem_we || clr_busy) stray++;
    end
    tests++; if (stray != 0) begin
      fails++; $display("FAIL no_residual: stray cycles=%0d, need 0", stray); end
    clr_req = 1'b1; clr_color = 8'h0F;
    step();
    clr_req = 1'b0;
    step();
    tests++; if (mem_we !== 1'b1 || mem_addr !== 19'd0 || mem_wdata !== 8'h0F || state !== 2'd2) begin
      fails++; $display("FAIL clr_restart: we=%b addr=%0d data=%h state=%0d, need 1/0/0f/2", mem_we, mem_addr, mem_wdata, state); end
  endtask

  initial begin
    test_reset();
    test_three_writes();
    test_push_pop();
    test_full_and_preempt();
    test_clear();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
- Time-shares the single-port 640x480 8-bit palette-index framebuffer between VGA scan-out reads and game-logic pixel writes.
- Scan-out owns the RAM port whenever active video is about to be fetched.
- Queued pixel writes and a full-screen clear are granted only in blanking cycles.
- Sits between the sync/address generator (upstream) and the framebuffer RAM (downstream).

Parameters:
- ADDR_W, 19, framebuffer address width.
- FB_WORDS, 307200, pixels per frame (640x480); the clear covers addresses 0..FB_WORDS-1.
- FIFO_DEPTH, 16, write-request FIFO entries; must be a power of 2.
- LVL_W, 5, width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- iVGA_CLK  in  1  pixel clock; all logic on posedge.
- iRST_n  in  1  asynchronous active-low reset.
- disp_active_next  in  1  1 = the next cycle is an active-video fetch; valid one cycle ahead of use.
- disp_addr_next  in  ADDR_W  scan-out address for the next cycle.
- wr_req  in  1  pixel write request.
- wr_addr  in  ADDR_W  pixel write address.
- wr_data  in  8  pixel palette index.
- wr_ready  out  1  request accepted this cycle when wr_req && wr_ready.
- clr_req  in  1  single-cycle pulse: fill the framebuffer with clr_color.
- clr_color  in  8  fill index, sampled when clr_req is accepted.
- clr_busy  out  1  a clear is pending or in progress.
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_wdata  out  8  RAM write data (registered).
- mem_we  out  1  RAM write enable (registered).
- fifo_level  out  LVL_W  current number of FIFO entries.
- state  out  2  0 DISP, 1 WRITE, 2 CLEAR, 3 IDLE (registered).

Behaviour:
- Reset (async, iRST_n=0):
  - mem_addr=0, mem_wdata=0, mem_we=0, state=DISP.
  - clr_busy=0, clear counter=0, FIFO empty, fifo_level=0.
  - Any in-progress clear or queued write is discarded; nothing resumes after reset.
- wr_ready is combinational: !fifo_full && !clr_busy, using registered state only.
- Push: occurs on a posedge when wr_req && wr_ready. A pop in the same cycle does not raise wr_ready.
- Minimum latency: a pushed entry can reach mem_we no earlier than the next posedge after the push.
- Per-posedge priority, highest first:
  - disp_active_next=1 → state=DISP; mem_addr<=disp_addr_next; mem_we<=0. No FIFO pop and no clear advance. Scan-out is never delayed.
  - else FIFO non-empty → state=WRITE; pop the head in FIFO order; mem_addr<=entry addr; mem_wdata<=entry data; mem_we<=1.
  - else clr_busy → state=CLEAR; mem_addr<=clr_cnt; mem_wdata<=clr_color_reg; mem_we<=1.
    - clr_cnt increments each CLEAR cycle.
    - On the cycle that writes FB_WORDS-1: clr_busy<=0 and clr_cnt<=0.
  - else → state=IDLE; mem_we<=0; mem_addr<=disp_addr_next.
- Clear:
  - clr_req is accepted only when clr_busy=0; clr_busy and clr_color_reg update on the next edge.
  - clr_req while busy is ignored, and clr_color is not re-sampled.
  - Entries queued before acceptance drain first, then are overwritten by the clear.
  - The clear spans as many blanking intervals as needed; clr_cnt holds across active video.
- Simultaneous push and pop: fifo_level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.
- Address checks: wr_addr is not range-checked, and the block never produces a clear address at or above FB_WORDS.
- mem_we is never 1 in a cycle following disp_active_next=1.

Test Plan:
- Reset released with disp_active_next=1, disp_addr_next=100 → next edge: mem_addr=100, mem_we=0, state=0, wr_ready=1, fifo_level=0.
- Push 3 writes (addr 5/6/7, data 0x11/0x22/0x33) during active video, then drop disp_active_next → fifo_level=3 and no mem_we while active; then three consecutive cycles mem_we=1 with (5,0x11), (6,0x22), (7,0x33); then state=IDLE.
- Push 16 writes during active video → fifo_level=16, wr_ready=0; a 17th wr_req is not accepted. The first blank cycle pops and wr_ready returns to 1 on the following cycle.
- disp_active_next rises mid-drain with 2 entries left → next edge mem_we=0 and mem_addr follows disp_addr_next; the remaining 2 entries drain in order at the next blanking.
- clr_req with clr_color=0x3C, then alternate 160 blank / 640 active cycles → 307200 writes of 0x3C at sequential addresses 0..307199, each exactly once. clr_busy drops after address 307199; wr_ready stays 0 throughout the clear.
- iRST_n pulsed low at clr_cnt=1000 with 4 FIFO entries → immediately mem_we=0, clr_busy=0, fifo_level=0; after release, no residual writes occur.
